gpio_in_filter: RTL



---
 rtl/gpio_in_filter.sv | 84 ++++++++
 1 files changed

// File: rtl/gpio_in_filter.sv
// Per-pin pad conditioning: two-flop resynchroniser, optional stability-count
// debounce, and registered rise/fall strobes aligned with the filtered level.
module gpio_in_filter #(
  parameter int Width    = 32,
  parameter int CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [Width-1:0]    gpio_pad_i,
  input  logic [Width-1:0]    filter_en_i,
  input  logic [CntWidth-1:0] filter_cycles_i,
  output logic [Width-1:0]    gpio_filt_o,
  output logic [Width-1:0]    gpio_rise_o,
  output logic [Width-1:0]    gpio_fall_o
);

  logic [Width-1:0]                sync1_q;
  logic [Width-1:0]                sync2_q;
  logic [Width-1:0]                filt_q;
  logic [Width-1:0]                filt_d;
  logic [Width-1:0]                rise_q;
  logic [Width-1:0]                rise_d;
  logic [Width-1:0]                fall_q;
  logic [Width-1:0]                fall_d;
  logic [Width-1:0][CntWidth-1:0]  cnt_q;
  logic [Width-1:0][CntWidth-1:0]  cnt_d;

  localparam logic [CntWidth-1:0] CntZero = {CntWidth{1'b0}};
  localparam logic [CntWidth-1:0] CntOne  = {{(CntWidth-1){1'b0}}, 1'b1};

  // Two-flop resynchroniser for the asynchronous pad levels
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= {Width{1'b0}};
      sync2_q <= {Width{1'b0}};
    end else begin
      sync1_q <= gpio_pad_i;
      sync2_q <= sync1_q;
    end
  end

  // Per-pin debounce decision; a returning sample discards the whole run
  always_comb begin
    filt_d = filt_q;
    cnt_d  = {Width{CntZero}};
    for (int i = 0; i < Width; i++) begin
      if (!filter_en_i[i]) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = CntZero;
      end else if (sync2_q[i] == filt_q[i]) begin
        filt_d[i] = filt_q[i];
        cnt_d[i]  = CntZero;
      end else if (cnt_q[i] >= filter_cycles_i) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = CntZero;
      end else begin
        filt_d[i] = filt_q[i];
        cnt_d[i]  = cnt_q[i] + CntOne;
      end
    end
    rise_d = filt_d & ~filt_q;
    fall_d = ~filt_d & filt_q;
  end

  // Filtered level, strobes and run counters update together
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q <= {Width{1'b0}};
      rise_q <= {Width{1'b0}};
      fall_q <= {Width{1'b0}};
      cnt_q  <= {Width{CntZero}};
    end else begin
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign gpio_filt_o = filt_q;
  assign gpio_rise_o = rise_q;
  assign gpio_fall_o = fall_q;

endmodule
